// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// in_ready is a flop, so a WB stall never reaches MEM through combinational logic.
module mem_wb_skid_stage #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RD_W        = 5,
  parameter bit          ZERO_SQUASH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_regwrite,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_regwrite,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic              in_ready_q;
  logic [DATA_W-1:0] main_data;
  logic              main_rw;
  logic [RD_W-1:0]   main_rd;
  logic [DATA_W-1:0] skid_data;
  logic              skid_rw;
  logic [RD_W-1:0]   skid_rd;

  logic accept;
  logic retire;
  logic cap_rw;

  always_comb begin
    accept = in_valid & in_ready_q;
    retire = (state != EMPTY) & out_ready;
    // writes to x0 are architecturally void; drop the enable at capture time
    if (ZERO_SQUASH)
      cap_rw = in_regwrite & (in_rd != '0);
    else
      cap_rw = in_regwrite;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_data  <= '0;
      main_rw    <= 1'b0;
      main_rd    <= '0;
      skid_data  <= '0;
      skid_rw    <= 1'b0;
      skid_rd    <= '0;
    end else if (flush) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_data <= in_data;
            main_rw   <= cap_rw;
            main_rd   <= in_rd;
            state     <= ONE;
          end
          in_ready_q <= 1'b1;
        end
        ONE: begin
          if (accept && retire) begin
            main_data <= in_data;
            main_rw   <= cap_rw;
            main_rd   <= in_rd;
          end else if (accept) begin
            skid_data  <= in_data;
            skid_rw    <= cap_rw;
            skid_rd    <= in_rd;
            state      <= FULL;
            in_ready_q <= 1'b0;
          end else if (retire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (retire) begin
            main_data  <= skid_data;
            main_rw    <= skid_rw;
            main_rd    <= skid_rd;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    in_ready     = in_ready_q;
    out_valid    = (state != EMPTY);
    out_data     = main_data;
    out_rd       = main_rd;
    out_regwrite = main_rw & out_valid;
    case (state)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: a queue model checked every cycle plus directed literal expectations.
module tb_mem_wb_skid_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_regwrite, out_ready;
  logic [DW-1:0] in_data;
  logic [RW-1:0] in_rd;

  logic          s_in_ready, s_out_valid, s_out_regwrite;
  logic [DW-1:0] s_out_data;
  logic [RW-1:0] s_out_rd;
  logic [1:0]    s_occ;

  logic          p_in_ready, p_out_valid, p_out_regwrite;
  logic [DW-1:0] p_out_data;
  logic [RW-1:0] p_out_rd;
  logic [1:0]    p_occ;

  always #5 clk = ~clk;

  mem_wb_skid_stage #(.DATA_W(DW), .RD_W(RW), .ZERO_SQUASH(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .in_regwrite(in_regwrite), .in_rd(in_rd),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_regwrite(s_out_regwrite), .out_rd(s_out_rd), .occupancy(s_occ)
  );

  mem_wb_skid_stage #(.DATA_W(DW), .RD_W(RW), .ZERO_SQUASH(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(p_in_ready), .in_data(in_data),
    .in_regwrite(in_regwrite), .in_rd(in_rd),
    .out_valid(p_out_valid), .out_ready(out_ready), .out_data(p_out_data),
    .out_regwrite(p_out_regwrite), .out_rd(p_out_rd), .occupancy(p_occ)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of at most two entries; the "last" entry is what the output holds when empty.
  typedef struct {
    logic [DW-1:0] d;
    logic          rw;
    logic [RW-1:0] rd;
  } ent_t;

  ent_t q[$];
  ent_t last;
  bit   chk_en = 1'b0;

  always @(posedge clk) begin
    bit acc, ret;
    ent_t e;
    acc = in_valid && (q.size() < 2);
    ret = out_ready && (q.size() > 0);
    if (rst) begin
      q.delete();
      last.d  = '0;
      last.rw = 1'b0;
      last.rd = '0;
      chk_en  = 1'b1;
    end else if (flush) begin
      if (q.size() > 0) last = q[0];
      q.delete();
    end else begin
      if (ret) begin
        last = q[0];
        void'(q.pop_front());
      end
      if (acc) begin
        e.d  = in_data;
        e.rw = in_regwrite;
        e.rd = in_rd;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      ent_t f;
      bit   v;
      v = (q.size() > 0);
      f = v ? q[0] : last;
      chk("m_valid", 64'(s_out_valid), 64'(v));
      chk("m_in_ready", 64'(s_in_ready), 64'(q.size() < 2));
      chk("m_occ", 64'(s_occ), 64'(q.size()));
      chk("m_data", 64'(s_out_data), 64'(f.d));
      chk("m_rd", 64'(s_out_rd), 64'(f.rd));
      chk("m_rw_sq", 64'(s_out_regwrite), 64'(v && f.rw && (f.rd != '0)));
      chk("m_rw_ns", 64'(p_out_regwrite), 64'(v && f.rw));
      chk("m_occ_ns", 64'(p_occ), 64'(q.size()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [RW-1:0] r, input logic w);
    in_valid    = 1'b1;
    in_data     = d;
    in_rd       = r;
    in_regwrite = w;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_regwrite = 1'b0;
    out_ready = 1'b0; in_data = '0; in_rd = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_occ", 64'(s_occ), 64'd0);
    chk("rst_ready", 64'(s_in_ready), 64'd1);

    // back-to-back streaming
    out_ready = 1'b1;
    send(32'h11, 5'd1, 1'b1); tick();
    chk("s1_data", 64'(s_out_data), 64'h11);
    send(32'h22, 5'd2, 1'b1); tick();
    chk("s2_data", 64'(s_out_data), 64'h22);
    chk("s2_valid", 64'(s_out_valid), 64'd1);
    send(32'h33, 5'd3, 1'b1); tick();
    chk("s3_data", 64'(s_out_data), 64'h33);
    chk("s3_rd", 64'(s_out_rd), 64'd3);
    in_valid = 1'b0; tick();
    chk("s_drain", 64'(s_out_valid), 64'd0);

    // stall fill then release
    out_ready = 1'b0;
    send(32'hA0, 5'd4, 1'b1); tick();
    chk("f1_occ", 64'(s_occ), 64'd1);
    send(32'hB0, 5'd5, 1'b1); tick();
    chk("f2_occ", 64'(s_occ), 64'd2);
    chk("f2_ready", 64'(s_in_ready), 64'd0);
    chk("f2_data", 64'(s_out_data), 64'hA0);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("f3_data", 64'(s_out_data), 64'hB0);
    chk("f3_ready", 64'(s_in_ready), 64'd1);
    tick();
    chk("f4_valid", 64'(s_out_valid), 64'd0);
    chk("f4_hold", 64'(s_out_data), 64'hB0);
    chk("f4_rw", 64'(s_out_regwrite), 64'd0);

    // reset mid-stream while full
    out_ready = 1'b0;
    send(32'hC1, 5'd6, 1'b1); tick();
    send(32'hC2, 5'd7, 1'b1); tick();
    chk("r_occ2", 64'(s_occ), 64'd2);
    rst = 1'b1; tick();
    chk("r_valid", 64'(s_out_valid), 64'd0);
    chk("r_ready", 64'(s_in_ready), 64'd1);
    chk("r_data", 64'(s_out_data), 64'd0);
    chk("r_rd", 64'(s_out_rd), 64'd0);
    tick();
    rst = 1'b0; in_valid = 1'b0; tick();

    // flush while full with a concurrent input
    send(32'hD1, 5'd8, 1'b1); tick();
    send(32'hD2, 5'd9, 1'b1); tick();
    send(32'hCC, 5'd10, 1'b1); flush = 1'b1; tick();
    chk("fl_valid", 64'(s_out_valid), 64'd0);
    chk("fl_occ", 64'(s_occ), 64'd0);
    chk("fl_ready", 64'(s_in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("fl_hold", 64'(s_out_data), 64'hD1);

    // zero-register squash
    out_ready = 1'b0;
    send(32'hDEAD, 5'd0, 1'b1); tick();
    chk("z_valid", 64'(s_out_valid), 64'd1);
    chk("z_rw_sq", 64'(s_out_regwrite), 64'd0);
    chk("z_rw_ns", 64'(p_out_regwrite), 64'd1);
    chk("z_data", 64'(s_out_data), 64'hDEAD);
    in_valid = 1'b0; out_ready = 1'b1; tick();

    // randomised traffic against the model
    for (int i = 0; i < 10000; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 63) == 0);
      rst         = ($urandom_range(0, 1023) == 0);
      in_data     = $urandom;
      in_rd       = RW'($urandom_range(0, 31));
      in_regwrite = $urandom_range(0, 1) != 0;
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    chk("end_empty", 64'(s_occ), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
